// File: rtl/mem_write_pkg.sv
// Shared SPI flash definitions for the memory write/read blocks: command
// opcodes, write size encodings, FSM state encoding and frame sizing.
package mem_write_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [1:0] SIZE_1B   = 2'b00;
  localparam logic [1:0] SIZE_2B   = 2'b01;
  localparam logic [1:0] SIZE_4B   = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int unsigned FRAME_BITS_MAX = 64;
  localparam int unsigned BYTE_IDX_W     = $clog2(FRAME_BITS_MAX / 8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Index of the final frame byte: 1 cmd + 3 addr bytes, then the data bytes.
  function automatic logic [BYTE_IDX_W-1:0] last_byte_idx(input logic [1:0] size);
    case (size)
      SIZE_1B: return BYTE_IDX_W'(4);
      SIZE_2B: return BYTE_IDX_W'(5);
      default: return BYTE_IDX_W'(7);
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: each bit spends one clk with sclk low, then one
// with sclk high; a load on the final high phase chains the next byte seamlessly.
module spi_byte_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       mosi_o,
  output logic       sclk_o,
  output logic       byte_done_o
);

  logic [6:0] shift_q;
  logic [2:0] bit_q;
  logic       active_q;
  logic       sclk_q;
  logic       mosi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else if (load_i) begin
      shift_q  <= byte_i[6:0];
      mosi_q   <= byte_i[7];
      sclk_q   <= 1'b0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else if (bit_q == 3'd7) begin
        active_q <= 1'b0;
        sclk_q   <= 1'b0;
        mosi_q   <= 1'b0;
      end else begin
        bit_q   <= bit_q + 3'd1;
        mosi_q  <= shift_q[6];
        shift_q <= {shift_q[5:0], 1'b0};
        sclk_q  <= 1'b0;
      end
    end
  end

  assign mosi_o      = mosi_q;
  assign sclk_o      = sclk_q;
  assign byte_done_o = active_q & sclk_q & (bit_q == 3'd7);

endmodule

// File: rtl/mem_write.sv
// SPI flash page-program master: sends 02h, a 24-bit address and 1/2/4
// little-endian data bytes, then holds write_done until the request drops.
module mem_write
  import mem_write_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_write,
  input  logic [23:0] target_address,
  input  logic [31:0] write_data,
  input  logic [1:0]  write_size,
  output logic        write_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);

  state_e                  state_q;
  logic [23:0]             addr_q;
  logic [31:0]             data_q;
  logic [BYTE_IDX_W-1:0]   byte_idx_q;
  logic [BYTE_IDX_W-1:0]   last_idx_q;
  logic                    start_load_q;
  logic                    cs_q;
  logic                    done_q;

  logic [BYTE_IDX_W-1:0]   next_idx;
  logic [7:0]              tx_byte;
  logic                    tx_load;
  logic                    tx_byte_done;

  always_comb begin
    next_idx = byte_idx_q + BYTE_IDX_W'(1);
    tx_byte  = SPI_CMD_WRITE;
    if (!start_load_q) begin
      case (next_idx)
        3'd1:    tx_byte = addr_q[23:16];
        3'd2:    tx_byte = addr_q[15:8];
        3'd3:    tx_byte = addr_q[7:0];
        3'd4:    tx_byte = data_q[7:0];
        3'd5:    tx_byte = data_q[15:8];
        3'd6:    tx_byte = data_q[23:16];
        3'd7:    tx_byte = data_q[31:24];
        default: tx_byte = SPI_CMD_WRITE;
      endcase
    end
  end

  // The next byte is loaded on the last sclk-high cycle so bits stay back to back.
  assign tx_load = start_load_q | (tx_byte_done & (byte_idx_q != last_idx_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      byte_idx_q   <= '0;
      last_idx_q   <= '0;
      start_load_q <= 1'b0;
      cs_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_write && !done_q) begin
            addr_q       <= target_address;
            data_q       <= write_data;
            last_idx_q   <= last_byte_idx(write_size);
            byte_idx_q   <= '0;
            start_load_q <= 1'b1;
            state_q      <= ST_CMD;
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          if (start_load_q) begin
            start_load_q <= 1'b0;
            cs_q         <= 1'b0;
          end
          if (tx_byte_done) begin
            if (byte_idx_q == last_idx_q) begin
              cs_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              byte_idx_q <= next_idx;
              state_q    <= (next_idx >= BYTE_IDX_W'(4)) ? ST_DATA : ST_ADDR;
            end
          end
        end
        ST_DONE: begin
          if (!start_write) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spi_byte_tx u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tx_load),
    .byte_i      (tx_byte),
    .mosi_o      (mosi),
    .sclk_o      (sclk),
    .byte_done_o (tx_byte_done)
  );

  assign cs         = cs_q;
  assign write_done = done_q;

endmodule
